// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the elastic pipeline stage
package pipe_pkg;

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    function automatic logic [CNT_W-1:0] state_count(pipe_state_t st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+ctrl+data holding register with load and clear
module pipe_slot #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // clear beats load so a flush always discards a same-cycle write; data is left stale
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ld_ctrl;
            data  <= ld_data;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic inter-stage register with flush, bubbles and optional skid
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    logic              accept;
    logic              pop;
    logic              main_load;
    logic              main_clear;
    logic              main_valid;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_ld_data;
    logic [DATA_W-1:0] main_data;

    assign accept    = in_valid & in_ready;
    assign pop       = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .clear   (main_clear),
        .load    (main_load),
        .ld_ctrl (main_ld_ctrl),
        .ld_data (main_ld_data),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_t       state;
            logic              in_ready_q;
            logic              skid_load;
            logic              skid_clear;
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            // the skid slot is only occupied in ST_TWO, so it doubles as the refill source select
            assign main_load    = (state == ST_EMPTY && accept)
                               || (state == ST_ONE && accept && pop)
                               || (state == ST_TWO && pop);
            assign main_clear   = flush || (state == ST_ONE && pop && !accept);
            assign skid_load    = (state == ST_ONE) && accept && !pop;
            assign skid_clear   = flush || (state == ST_TWO && pop);
            assign main_ld_ctrl = skid_valid ? skid_ctrl : in_ctrl;
            assign main_ld_data = skid_valid ? skid_data : in_data;
            assign in_ready     = in_ready_q;
            assign count        = state_count(state);

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .clear   (skid_clear),
                .load    (skid_load),
                .ld_ctrl (in_ctrl),
                .ld_data (in_data),
                .valid   (skid_valid),
                .ctrl    (skid_ctrl),
                .data    (skid_data)
            );

            // in_ready is registered alongside the state so out_ready never reaches it
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    state      <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (accept) state <= ST_ONE;
                        end
                        ST_ONE: begin
                            if (accept && !pop) begin
                                state      <= ST_TWO;
                                in_ready_q <= 1'b0;
                            end else if (!accept && pop) begin
                                state <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (pop) begin
                                state      <= ST_ONE;
                                in_ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state      <= ST_EMPTY;
                            in_ready_q <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_single
            assign main_load    = accept;
            assign main_clear   = flush || (pop && !accept);
            assign main_ld_ctrl = in_ctrl;
            assign main_ld_data = in_data;
            assign in_ready     = !main_valid || out_ready;
            assign count        = CNT_W'(main_valid);
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - bench for pipe_stage_elastic, skid and non-skid builds side by side
module tb_pipe_stage_elastic;

    typedef struct packed {
        logic [15:0] c;
        logic [95:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [15:0] in_ctrl;
    logic [95:0] in_data;

    logic        r1, v1, r0, v0;
    logic [15:0] c1, c0;
    logic [95:0] dt1, dt0;
    logic [1:0]  n1, n0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    ent_t q1[$];
    ent_t q0[$];

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(96), .CTRL_W(16), .SKID(1)) u_s1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v1), .out_ready(out_ready), .out_ctrl(c1), .out_data(dt1),
        .count(n1)
    );

    pipe_stage_elastic #(.DATA_W(96), .CTRL_W(16), .SKID(0)) u_s0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v0), .out_ready(out_ready), .out_ctrl(c0), .out_data(dt0),
        .count(n0)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // reference: a FIFO of at most 2 (skid) or 1 (single) entries
    always @(posedge clk) begin
        logic a1, p1, a0, p0;
        if (rst) begin
            q1.delete();
            q0.delete();
        end else begin
            p1 = (q1.size() > 0) && out_ready;
            a1 = in_valid && (q1.size() < 2);
            p0 = (q0.size() > 0) && out_ready;
            a0 = in_valid && ((q0.size() == 0) || out_ready);
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (p1) void'(q1.pop_front());
                if (a1) q1.push_back('{c: in_ctrl, d: in_data});
                if (p0) void'(q0.pop_front());
                if (a0) q0.push_back('{c: in_ctrl, d: in_data});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s1 out_valid", v1, q1.size() > 0);
            chk("s1 count", n1, q1.size());
            chk("s1 in_ready", r1, q1.size() < 2);
            chk("s1 out_ctrl", c1, (q1.size() > 0) ? q1[0].c : 16'h0);
            if (q1.size() > 0) chk("s1 out_data", dt1, q1[0].d);
            chk("s0 out_valid", v0, q0.size() > 0);
            chk("s0 count", n0, q0.size());
            chk("s0 in_ready", r0, (q0.size() == 0) || out_ready);
            chk("s0 out_ctrl", c0, (q0.size() > 0) ? q0[0].c : 16'h0);
            if (q0.size() > 0) chk("s0 out_data", dt0, q0[0].d);
        end
    end

    initial begin
        int thr;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_ctrl = 16'hffff; in_data = 96'h5;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("t1 s1 out_valid", v1, 0);
        chk("t1 s1 out_ctrl", c1, 0);
        chk("t1 s1 out_data", dt1, 0);
        chk("t1 s1 count", n1, 0);
        chk("t1 s1 in_ready", r1, 1);
        chk("t1 s0 out_valid", v0, 0);
        chk("t1 s0 count", n0, 0);
        chk("t1 s0 in_ready", r0, 1);

        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 96'(i); in_ctrl = 16'h100 + 16'(i);
            tick();
            chk("t2 s1 out_data", dt1, i);
            chk("t2 s1 out_ctrl", c1, 16'h100 + 16'(i));
            chk("t2 s1 count", n1, 1);
            chk("t2 s0 out_data", dt0, i);
            chk("t2 s0 count", n0, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("t2 s1 drained", v1, 0);
        chk("t2 s0 drained", v0, 0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 96'hA; in_ctrl = 16'h0A0A;
        tick();
        in_data = 96'hB; in_ctrl = 16'h0B0B;
        tick();
        in_valid = 1'b0;
        #1;
        chk("t3 s1 count", n1, 2);
        chk("t3 s1 in_ready", r1, 0);
        chk("t3 s1 head", dt1, 96'hA);
        chk("t5 s0 in_ready stall", r0, 0);
        chk("t5 s0 head", dt0, 96'hA);
        tick();
        chk("t3 s1 hold data", dt1, 96'hA);
        chk("t3 s1 hold ctrl", c1, 16'h0A0A);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 96'hC; in_ctrl = 16'h0C0C;
        #1;
        chk("t5 s0 in_ready comb", r0, 1);
        chk("t3 s1 in_ready full", r1, 0);
        tick();
        chk("t3 s1 second", dt1, 96'hB);
        chk("t3 s1 count", n1, 1);
        chk("t5 s0 replaced", dt0, 96'hC);
        chk("t5 s0 count", n0, 1);
        in_valid = 1'b0;
        tick();
        chk("t3 s1 empty", v1, 0);
        chk("t5 s0 empty", v0, 0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 96'hD; in_ctrl = 16'h0D0D;
        tick();
        in_data = 96'hE; in_ctrl = 16'h0E0E;
        tick();
        chk("t4 s1 full", n1, 2);
        flush = 1'b1; in_data = 96'hF; in_ctrl = 16'h0F0F;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("t4 s1 out_valid", v1, 0);
        chk("t4 s1 out_ctrl", c1, 0);
        chk("t4 s1 count", n1, 0);
        chk("t4 s1 in_ready", r1, 1);
        chk("t4 s0 out_valid", v0, 0);
        chk("t4 s0 out_ctrl", c0, 0);
        chk("t4 s0 count", n0, 0);
        out_ready = 1'b1;
        tick();
        chk("t4 s1 no F", v1, 0);
        chk("t4 s0 no F", v0, 0);

        thr = 50;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc % 500 == 0) begin
                case ($urandom % 3)
                    0:       thr = 20;
                    1:       thr = 50;
                    default: thr = 90;
                endcase
            end
            rst       = ($urandom % 512) == 0;
            flush     = ($urandom % 48) == 0;
            in_valid  = ($urandom % 4) != 0;
            out_ready = int'($urandom % 100) < thr;
            in_data   = {$urandom, $urandom, $urandom};
            in_ctrl   = (($urandom % 8) == 0) ? 16'h0 : 16'($urandom);
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
